// File: rtl/umul_pkg.sv
// Shared state encoding, Sobol direction numbers and width helper for the
// unary-rate border multiplier (mul_border_acc) and its Sobol generators.
package umul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SOBOL_DIMS = 2;
  localparam int SOBOL_BITS = 16;

  // Direction numbers are left-aligned in 16 bits; an N-bit generator keeps the top N bits.
  localparam logic [15:0] SOBOL_DIRV [SOBOL_DIMS][SOBOL_BITS] = '{
    '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100,
      16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001},
    '{16'h8000, 16'hC000, 16'hA000, 16'hF000, 16'h8800, 16'hCC00, 16'hAA00, 16'hFF00,
      16'h8080, 16'hC0C0, 16'hA0A0, 16'hF0F0, 16'h8888, 16'hCCCC, 16'hAAAA, 16'hFFFF}
  };

  function automatic int sobol_width(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/mul_border_acc_sobol.sv
// Gray-code Sobol generator: value 0 at index 0, one new point per enabled cycle;
// clr restarts the sequence synchronously.
module sobol_gen
  import umul_pkg::*;
#(
  parameter int N   = 15,
  parameter int DIM = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         enable,
  output logic [N-1:0] o_rand
);

  logic [N-1:0] r_idx;
  logic [N-1:0] r_val;
  logic [N-1:0] w_dir [N];
  logic [N-1:0] w_step;
  logic         w_found;

  for (genvar k = 0; k < N; k++) begin : g_dir
    assign w_dir[k] = N'(SOBOL_DIRV[DIM][k] >> (SOBOL_BITS - N));
  end

  // Step direction is chosen by the lowest zero bit of the index; the all-ones
  // index falls back to the top direction so the sequence wraps cleanly to 0.
  always_comb begin
    w_step  = w_dir[N-1];
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && !r_idx[i]) begin
        w_step  = w_dir[i];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_idx <= '0;
      r_val <= '0;
    end else if (enable) begin
      r_idx <= r_idx + N'(1);
      r_val <= r_val ^ w_step;
    end
  end

  assign o_rand = r_val;

endmodule

// File: rtl/mul_border_acc.sv
// Border multiplier: one operand pair per 2^N-cycle Sobol window, streaming product bits
// and an exact ones-count result. Define MUL_BORDER_SIGNED_EN for sign-magnitude operands.
module mul_border_acc
  import umul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIM_I = 0,
  parameter int DIM_W = 1,
  localparam int N  = sobol_width(WIDTH),
`ifdef MUL_BORDER_SIGNED_EN
  localparam int DW = WIDTH
`else
  localparam int DW = sobol_width(WIDTH)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data_i,
  input  logic [DW-1:0] i_data_w,
  output logic          o_bit,
  output logic          o_bit_vld,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_prod
);

  state_e       r_state;
  logic [N-1:0] r_mi;
  logic [N-1:0] r_mw;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_cyc;

  logic [N-1:0] w_magI;
  logic [N-1:0] w_magW;
  logic [N-1:0] w_randI;
  logic [N-1:0] w_randW;
  logic         w_run;
  logic         w_accept;
  logic         w_winEnd;
  logic         w_bitI;
  logic         w_bitW;
  logic         w_prodBit;

`ifdef MUL_BORDER_SIGNED_EN
  logic r_si;
  logic r_sw;

  assign w_magI = i_data_i[N-1:0];
  assign w_magW = i_data_w[N-1:0];
`else
  assign w_magI = i_data_i;
  assign w_magW = i_data_w;
`endif

  assign w_run     = (r_state == RUN);
  assign w_accept  = i_valid && (r_state == IDLE);
  assign w_winEnd  = (r_cyc == '1);
  assign w_bitI    = (r_mi > w_randI);
  assign w_bitW    = (r_mw > w_randW);
  assign w_prodBit = w_run & w_bitI & w_bitW;

  // The weight stream only advances on input ones, decorrelating the two streams.
  sobol_gen #(.N(N), .DIM(DIM_I)) u_rngI (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept),
    .enable (w_run),
    .o_rand (w_randI)
  );

  sobol_gen #(.N(N), .DIM(DIM_W)) u_rngW (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept),
    .enable (w_run & w_bitI),
    .o_rand (w_randW)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mi    <= '0;
      r_mw    <= '0;
      r_acc   <= '0;
      r_cyc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_state <= RUN;
            r_mi    <= w_magI;
            r_mw    <= w_magW;
            r_acc   <= '0;
            r_cyc   <= '0;
          end
        end
        RUN: begin
          r_acc <= r_acc + N'(w_prodBit);
          r_cyc <= r_cyc + N'(1);
          if (w_winEnd) r_state <= DONE;
        end
        DONE: begin
          if (o_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MUL_BORDER_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_si <= 1'b0;
      r_sw <= 1'b0;
    end else if (w_accept) begin
      r_si <= i_data_i[WIDTH-1];
      r_sw <= i_data_w[WIDTH-1];
    end
  end

  // A zero magnitude always reports a positive sign.
  assign o_prod = {(r_si ^ r_sw) & (r_acc != '0), r_acc};
`else
  assign o_prod = r_acc;
`endif

  assign i_ready   = (r_state == IDLE);
  assign o_valid   = (r_state == DONE);
  assign o_bit_vld = w_run;
  assign o_bit     = w_prodBit;

endmodule
